// File: rtl/otter_dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// otter_dmem_arbiter_if : CPU/DMA request buses and memory port 2 signals
// Rev 1.0
// ============================================================================
interface otter_dmem_arbiter_if;
    logic        CPU_REQ,   DMA_REQ;
    logic        CPU_WE,    DMA_WE;
    logic [31:0] CPU_ADDR,  DMA_ADDR;
    logic [31:0] CPU_WDATA, DMA_WDATA;
    logic [1:0]  CPU_SIZE,  DMA_SIZE;
    logic        CPU_SIGN,  DMA_SIGN;
    logic        CPU_LOCK,  DMA_LOCK;
    logic        CPU_GNT,   DMA_GNT;
    logic        CPU_RVALID, DMA_RVALID;
    logic [31:0] CPU_RDATA, DMA_RDATA;
    logic        CPU_ERR,   DMA_ERR;
    logic [31:0] MEM_ADDR2;
    logic [31:0] MEM_DIN2;
    logic        MEM_WRITE2;
    logic        MEM_READ2;
    logic [1:0]  MEM_SIZE;
    logic        MEM_SIGN;
    logic [31:0] MEM_DOUT2;

    modport slave (
        input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, CPU_SIZE, CPU_SIGN, CPU_LOCK,
        input  DMA_REQ, DMA_WE, DMA_ADDR, DMA_WDATA, DMA_SIZE, DMA_SIGN, DMA_LOCK,
        input  MEM_DOUT2,
        output CPU_GNT, CPU_RVALID, CPU_RDATA, CPU_ERR,
        output DMA_GNT, DMA_RVALID, DMA_RDATA, DMA_ERR,
        output MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
    );

    modport master (
        output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, CPU_SIZE, CPU_SIGN, CPU_LOCK,
        output DMA_REQ, DMA_WE, DMA_ADDR, DMA_WDATA, DMA_SIZE, DMA_SIGN, DMA_LOCK,
        output MEM_DOUT2,
        input  CPU_GNT, CPU_RVALID, CPU_RDATA, CPU_ERR,
        input  DMA_GNT, DMA_RVALID, DMA_RDATA, DMA_ERR,
        input  MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
    );
endinterface
`default_nettype wire

// File: rtl/otter_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// otter_dmem_arbiter : CPU/DMA arbiter for OTTER memory data port 2 with bus
// lock and misalignment rejection. Option: OTTER_DMEM_ARB_FAIRNESS_EN.
// Rev 1.0
// ============================================================================
module otter_dmem_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 4
) (
    input  wire logic           CLK,
    input  wire logic           RST_N,
    otter_dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCK_CPU = 2'd1,
        LOCK_DMA = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_gnt_cpu;
    logic        w_gnt_dma;
    logic        w_gnt_any;
    logic        w_dma_first;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [1:0]  w_size;
    logic        w_sign;
    logic        w_mis;
    logic        r_pend;
    logic        r_owner_dma;
    logic        r_err;

    if (MAX_WAIT < 1 || MAX_WAIT >= (1 << CNT_W)) begin : g_bad_cfg
        $error("otter_dmem_arbiter: CNT_W cannot hold MAX_WAIT");
    end

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == 2'd3) || (size == 2'd1 && lo == 2'd3) || (size == 2'd2 && lo != 2'd0);
    endfunction

`ifdef OTTER_DMEM_ARB_FAIRNESS_EN
    localparam logic [CNT_W-1:0] c_max_wait = CNT_W'(MAX_WAIT);
    logic [CNT_W-1:0] r_starve_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_starve_cnt <= '0;
        end else if (!bus.DMA_REQ || w_gnt_dma) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_max_wait) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign w_dma_first = (r_starve_cnt == c_max_wait);
`else
    assign w_dma_first = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grants are gated by RST_N so the outputs sit at reset values while it is low.
    always_comb begin
        w_gnt_cpu   = 1'b0;
        w_gnt_dma   = 1'b0;
        w_state_nxt = r_state;
        if (RST_N) begin
            unique case (r_state)
                IDLE: begin
                    if (bus.DMA_REQ && (w_dma_first || !bus.CPU_REQ)) begin
                        w_gnt_dma = 1'b1;
                    end else if (bus.CPU_REQ) begin
                        w_gnt_cpu = 1'b1;
                    end
                end
                LOCK_CPU: w_gnt_cpu = bus.CPU_REQ;
                LOCK_DMA: w_gnt_dma = bus.DMA_REQ;
                default:  w_state_nxt = IDLE;
            endcase
        end
        if (w_gnt_cpu) begin
            w_state_nxt = bus.CPU_LOCK ? LOCK_CPU : IDLE;
        end else if (w_gnt_dma) begin
            w_state_nxt = bus.DMA_LOCK ? LOCK_DMA : IDLE;
        end else if (r_state == LOCK_CPU && !bus.CPU_LOCK) begin
            w_state_nxt = IDLE;
        end else if (r_state == LOCK_DMA && !bus.DMA_LOCK) begin
            w_state_nxt = IDLE;
        end
    end

    assign w_gnt_any = w_gnt_cpu | w_gnt_dma;
    assign w_we      = w_gnt_dma ? bus.DMA_WE    : bus.CPU_WE;
    assign w_addr    = w_gnt_dma ? bus.DMA_ADDR  : bus.CPU_ADDR;
    assign w_wdata   = w_gnt_dma ? bus.DMA_WDATA : bus.CPU_WDATA;
    assign w_size    = w_gnt_dma ? bus.DMA_SIZE  : bus.CPU_SIZE;
    assign w_sign    = w_gnt_dma ? bus.DMA_SIGN  : bus.CPU_SIGN;
    assign w_mis     = misaligned(w_size, w_addr[1:0]);

    assign bus.CPU_GNT    = w_gnt_cpu;
    assign bus.DMA_GNT    = w_gnt_dma;
    assign bus.MEM_ADDR2  = w_gnt_any ? w_addr  : 32'h0;
    assign bus.MEM_DIN2   = w_gnt_any ? w_wdata : 32'h0;
    assign bus.MEM_SIZE   = w_gnt_any ? w_size  : 2'd0;
    assign bus.MEM_SIGN   = w_gnt_any & w_sign;
    assign bus.MEM_WRITE2 = w_gnt_any & ~w_mis & w_we;
    assign bus.MEM_READ2  = w_gnt_any & ~w_mis & ~w_we;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pend      <= 1'b0;
            r_owner_dma <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_pend      <= w_gnt_any;
            r_owner_dma <= w_gnt_dma;
            r_err       <= w_gnt_any & w_mis;
        end
    end

    assign bus.CPU_RVALID = r_pend & ~r_owner_dma;
    assign bus.DMA_RVALID = r_pend &  r_owner_dma;
    assign bus.CPU_ERR    = bus.CPU_RVALID & r_err;
    assign bus.DMA_ERR    = bus.DMA_RVALID & r_err;
    assign bus.CPU_RDATA  = (bus.CPU_RVALID && !r_err) ? bus.MEM_DOUT2 : 32'h0;
    assign bus.DMA_RDATA  = (bus.DMA_RVALID && !r_err) ? bus.MEM_DOUT2 : 32'h0;
endmodule
`default_nettype wire
